// File: rtl/systolic_pe.sv
// systolic_pe: weight-stationary MAC cell for the CNN systolic array.
//
// A double-buffered weight lets the next tile's weight shift down the column
// through the shadow register while the active weight keeps computing. The
// operands can be signed or unsigned, and the sum can saturate or wrap. A
// sticky flag records overflow, and a counter tracks the MACs done in the tile.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   mode_signed              1 = two's-complement operands, 0 = unsigned
//   sat_en                   1 = clamp on overflow, 0 = wrap
//   w_load, w_in, w_out      column weight shift chain (shadow register)
//   w_swap, w_swap_out       shadow -> active copy, and the wave passed right
//   a_valid_in, a_in         activation and valid from the left
//   a_valid_out, a_out       registered activation and valid, to the right
//   p_in, p_out              partial sum from above and to below
//   ovf_clr, ovf_flag        sticky overflow flag and its clear
//   mac_cnt                  valid MACs since the last swap or reset
module systolic_pe #(
  parameter int unsigned A_BITWIDTH   = 16,
  parameter int unsigned W_BITWIDTH   = 8,
  parameter int unsigned P_BITWIDTH   = 40,
  parameter int unsigned CNT_BITWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode_signed,
  input  logic                    sat_en,
  input  logic                    w_load,
  input  logic [W_BITWIDTH-1:0]   w_in,
  output logic [W_BITWIDTH-1:0]   w_out,
  input  logic                    w_swap,
  output logic                    w_swap_out,
  input  logic                    a_valid_in,
  input  logic [A_BITWIDTH-1:0]   a_in,
  output logic                    a_valid_out,
  output logic [A_BITWIDTH-1:0]   a_out,
  input  logic [P_BITWIDTH-1:0]   p_in,
  output logic [P_BITWIDTH-1:0]   p_out,
  input  logic                    ovf_clr,
  output logic                    ovf_flag,
  output logic [CNT_BITWIDTH-1:0] mac_cnt
);

  // The arithmetic uses one guard bit above the partial-sum width. This is
  // enough for the product and the sum, because P >= A + W + 1.
  localparam int unsigned XW = P_BITWIDTH + 1;

  logic [W_BITWIDTH-1:0]   r_shadow;
  logic [W_BITWIDTH-1:0]   r_active;
  logic [A_BITWIDTH-1:0]   r_a_out;
  logic                    r_a_valid;
  logic [P_BITWIDTH-1:0]   r_p_out;
  logic                    r_swap_out;
  logic                    r_ovf;
  logic [CNT_BITWIDTH-1:0] r_cnt;

  logic [XW-1:0]         w_w_ext;
  logic [XW-1:0]         w_a_ext;
  logic [XW-1:0]         w_p_ext;
  logic [XW-1:0]         w_prod;
  logic [XW-1:0]         w_sum;
  logic                  w_ovf;
  logic [P_BITWIDTH-1:0] w_p_next;

  always_comb begin
    if (mode_signed) begin
      w_w_ext = {{(XW - W_BITWIDTH){r_active[W_BITWIDTH-1]}}, r_active};
      w_a_ext = {{(XW - A_BITWIDTH){a_in[A_BITWIDTH-1]}}, a_in};
      w_p_ext = {{(XW - P_BITWIDTH){p_in[P_BITWIDTH-1]}}, p_in};
    end else begin
      w_w_ext = {{(XW - W_BITWIDTH){1'b0}}, r_active};
      w_a_ext = {{(XW - A_BITWIDTH){1'b0}}, a_in};
      w_p_ext = {{(XW - P_BITWIDTH){1'b0}}, p_in};
    end
    // The low XW bits of the product are correct for both signed and
    // unsigned operands.
    w_prod = w_w_ext * w_a_ext;
    w_sum  = w_p_ext + w_prod;

    // Signed: the guard bit disagrees with the P-bit sign bit.
    // Unsigned: a carry out of the P bits.
    if (mode_signed) w_ovf = w_sum[XW-1] ^ w_sum[XW-2];
    else             w_ovf = w_sum[XW-1];

    w_p_next = w_sum[P_BITWIDTH-1:0];
    if (w_ovf && sat_en) begin
      if (!mode_signed)     w_p_next = '1;
      else if (w_sum[XW-1]) w_p_next = {1'b1, {(P_BITWIDTH - 1){1'b0}}};
      else                  w_p_next = {1'b0, {(P_BITWIDTH - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow   <= '0;
      r_active   <= '0;
      r_a_out    <= '0;
      r_a_valid  <= 1'b0;
      r_p_out    <= '0;
      r_swap_out <= 1'b0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_load) r_shadow <= w_in;
      // The swap reads the shadow value from before this edge, so a load in
      // the same cycle does not reach the active weight.
      if (w_swap) r_active <= r_shadow;
      r_swap_out <= w_swap;

      r_a_valid <= a_valid_in;
      r_a_out   <= a_valid_in ? a_in : '0;
      r_p_out   <= a_valid_in ? w_p_next : '0;

      // The clear has priority over a new overflow.
      if (ovf_clr)                  r_ovf <= 1'b0;
      else if (a_valid_in && w_ovf) r_ovf <= 1'b1;

      // The swap clear has priority over a valid MAC. The count stops at all-ones.
      if (w_swap)                         r_cnt <= '0;
      else if (a_valid_in && ~&r_cnt)     r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_out       = r_shadow;
  assign w_swap_out  = r_swap_out;
  assign a_out       = r_a_out;
  assign a_valid_out = r_a_valid;
  assign p_out       = r_p_out;
  assign ovf_flag    = r_ovf;
  assign mac_cnt     = r_cnt;

endmodule
